// File: rtl/beat_grid_pkg.sv
// Shared geometry, colour constants and pixel attribute record for the beat-sequencer pad grid.
package beat_grid_pkg;
  localparam int ROWS    = 4;
  localparam int STEPS   = 16;
  localparam int CELL    = 40;
  localparam int SPR     = 35;
  localparam int GRID_Y0 = 160;

  localparam logic [11:0] COL_BLACK   = 12'h000;
  localparam logic [11:0] COL_OUTSIDE = 12'h111;
  localparam logic [11:0] COL_GUTTER  = 12'h333;
  localparam logic [11:0] COL_CURSOR  = 12'hFF0;
  localparam logic [11:0] CUR_TINT    = 12'h444;

  typedef struct packed {
    logic blank;
    logic in_grid;
    logic in_spr;
    logic on;
    logic cur;
  } pixel_attr_t;

  // Quarter brightness: each 4-bit channel shifted right by two.
  function automatic logic [11:0] dim_colour(input logic [11:0] c);
    return {2'b00, c[11:10], 2'b00, c[7:6], 2'b00, c[3:2]};
  endfunction
endpackage

// File: rtl/pad_grid_scheduler_if.sv
// Shared instrument-sprite ROM port: address/select out, palette index and colour back.
interface pad_grid_scheduler_if;
  logic [10:0] rom_address;
  logic [1:0]  rom_sel;
  logic        rom_q;
  logic [3:0]  pal_r;
  logic [3:0]  pal_g;
  logic [3:0]  pal_b;

  modport master (output rom_address, rom_sel, input rom_q, pal_r, pal_g, pal_b);
  modport slave  (input rom_address, rom_sel, output rom_q, pal_r, pal_g, pal_b);
endinterface

// File: rtl/pad_pattern_regs.sv
// 4x16 pad pattern with toggle port, play-step counter and per-row trigger pulses.
module pad_pattern_regs
  import beat_grid_pkg::*;
(
  input  logic                  vga_clk,
  input  logic                  Reset,
  input  logic                  run,
  input  logic                  restart,
  input  logic                  step_tick,
  input  logic                  pad_toggle,
  input  logic [1:0]            pad_row,
  input  logic [3:0]            pad_col,
  output logic [ROWS*STEPS-1:0] pattern,
  output logic [3:0]            step,
  output logic [ROWS-1:0]       trig
);
  logic [ROWS*STEPS-1:0] pattern_reg, pattern_next;
  logic [3:0]            step_reg, step_next;
  logic [ROWS-1:0]       trig_reg, trig_next;
  logic                  advance;
  logic [3:0]            step_inc;

  assign advance  = step_tick && run && !restart;
  assign step_inc = step_reg + 4'd1;

  // Triggers read the pattern before any same-cycle toggle lands.
  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_trig
      logic [STEPS-1:0] row_bits;
      assign row_bits      = pattern_reg[gi*STEPS +: STEPS];
      assign trig_next[gi] = advance & row_bits[step_inc];
    end
  endgenerate

  always_comb begin
    pattern_next = pattern_reg;
    if (pad_toggle)
      pattern_next[{pad_row, pad_col}] = ~pattern_reg[{pad_row, pad_col}];
    step_next = step_reg;
    if (restart)
      step_next = 4'd0;
    else if (advance)
      step_next = step_inc;
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      pattern_reg <= '0;
      step_reg    <= 4'd0;
      trig_reg    <= '0;
    end else begin
      pattern_reg <= pattern_next;
      step_reg    <= step_next;
      trig_reg    <= trig_next;
    end
  end

  assign pattern = pattern_reg;
  assign step    = step_reg;
  assign trig    = trig_reg;
endmodule

// File: rtl/pad_grid_scheduler.sv
// Pad-grid sequencer top: pixel-to-cell map, sprite ROM addressing and two-stage colour pipeline.
module pad_grid_scheduler
  import beat_grid_pkg::*;
(
  input  logic                        vga_clk,
  input  logic                        Reset,
  input  logic [9:0]                  DrawX,
  input  logic [9:0]                  DrawY,
  input  logic                        blank,
  input  logic                        run,
  input  logic                        restart,
  input  logic                        step_tick,
  input  logic                        pad_toggle,
  input  logic [1:0]                  pad_row,
  input  logic [3:0]                  pad_col,
  pad_grid_scheduler_if.master        rom,
  output logic [3:0]                  trig,
  output logic [3:0]                  step,
  output logic [3:0]                  red,
  output logic [3:0]                  green,
  output logic [3:0]                  blue
);
  localparam logic [9:0]  GY0_W    = 10'(GRID_Y0);
  localparam logic [9:0]  GY_END_W = 10'(GRID_Y0 + ROWS*CELL);
  localparam logic [9:0]  CELL_W   = 10'(CELL);
  localparam logic [9:0]  SPR_W    = 10'(SPR);
  localparam logic [10:0] SPR_A    = 11'(SPR);

  logic [ROWS*STEPS-1:0] pattern;

  pad_pattern_regs u_pattern (
    .vga_clk    (vga_clk),
    .Reset      (Reset),
    .run        (run),
    .restart    (restart),
    .step_tick  (step_tick),
    .pad_toggle (pad_toggle),
    .pad_row    (pad_row),
    .pad_col    (pad_col),
    .pattern    (pattern),
    .step       (step),
    .trig       (trig)
  );

  // Stage 0: cell lookup by constant-threshold compares, no divider.
  logic [9:0]  grid_dy, sx, sy;
  logic [1:0]  row;
  logic [3:0]  col;
  logic        in_grid, in_spr;
  logic [10:0] addr_calc;

  assign grid_dy = DrawY - GY0_W;
  assign in_grid = (DrawY >= GY0_W) && (DrawY < GY_END_W);

  always_comb begin
    row = 2'd0;
    for (int i = 1; i < ROWS; i++)
      if (grid_dy >= 10'(i*CELL)) row = 2'(i);
    col = 4'd0;
    for (int i = 1; i < STEPS; i++)
      if (DrawX >= 10'(i*CELL)) col = 4'(i);
  end

  assign sx        = DrawX - {6'd0, col} * CELL_W;
  assign sy        = grid_dy - {8'd0, row} * CELL_W;
  assign in_spr    = in_grid && (sx < SPR_W) && (sy < SPR_W);
  assign addr_calc = {1'b0, sy} * SPR_A + {1'b0, sx};

  // Cursor column is frozen for the whole frame to avoid tearing.
  logic [3:0]  cur_step_reg;
  pixel_attr_t attr_reg, attr_next;
  logic [10:0] rom_address_reg;
  logic [1:0]  rom_sel_reg;
  logic [11:0] colour_reg, colour_next;
  logic [11:0] pal;

  always_comb begin
    attr_next.blank   = blank;
    attr_next.in_grid = in_grid;
    attr_next.in_spr  = in_spr;
    attr_next.on      = pattern[{row, col}];
    attr_next.cur     = (col == cur_step_reg);
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      cur_step_reg    <= 4'd0;
      attr_reg        <= '0;
      rom_address_reg <= 11'd0;
      rom_sel_reg     <= 2'd0;
    end else begin
      if (DrawX == 10'd0 && DrawY == 10'd0)
        cur_step_reg <= step;
      attr_reg        <= attr_next;
      rom_address_reg <= in_spr ? addr_calc : 11'd0;
      rom_sel_reg     <= in_grid ? row : 2'd0;
    end
  end

  assign rom.rom_address = rom_address_reg;
  assign rom.rom_sel     = rom_sel_reg;
  assign pal             = {rom.pal_r, rom.pal_g, rom.pal_b};

  // Stage 2: palette arrives one edge after the address, via the negedge ROM.
  always_comb begin
    colour_next = COL_BLACK;
    if (!attr_reg.blank)
      colour_next = COL_BLACK;
    else if (!attr_reg.in_grid)
      colour_next = COL_OUTSIDE;
    else if (!attr_reg.in_spr)
      colour_next = attr_reg.cur ? COL_CURSOR : COL_GUTTER;
    else begin
      colour_next = attr_reg.on ? pal : dim_colour(pal);
      if (attr_reg.cur)
        colour_next = colour_next | CUR_TINT;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (Reset)
      colour_reg <= COL_BLACK;
    else
      colour_reg <= colour_next;
  end

  assign red   = colour_reg[11:8];
  assign green = colour_reg[7:4];
  assign blue  = colour_reg[3:0];
endmodule

// File: tb/tb_pad_grid_scheduler.sv
// Self-checking bench for pad_grid_scheduler: step/trig sequences plus a pixel vector table.
module tb_pad_grid_scheduler;
  logic       vga_clk = 1'b0;
  logic       Reset;
  logic [9:0] DrawX, DrawY;
  logic       blank, run, restart, step_tick, pad_toggle;
  logic [1:0] pad_row;
  logic [3:0] pad_col;
  logic [3:0] trig, step, red, green, blue;

  int errors = 0;
  int checks = 0;

  always #5 vga_clk = ~vga_clk;

  pad_grid_scheduler_if rom_bus();

  // Negedge-clocked ROM stand-in; colour comes from the pal_* values the bench drives.
  always @(negedge vga_clk) rom_bus.rom_q <= rom_bus.rom_address[0];

  pad_grid_scheduler dut (
    .vga_clk    (vga_clk),
    .Reset      (Reset),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .blank      (blank),
    .run        (run),
    .restart    (restart),
    .step_tick  (step_tick),
    .pad_toggle (pad_toggle),
    .pad_row    (pad_row),
    .pad_col    (pad_col),
    .rom        (rom_bus),
    .trig       (trig),
    .step       (step),
    .red        (red),
    .green      (green),
    .blue       (blue)
  );

  typedef struct {
    int          x;
    int          y;
    bit          b;
    logic [11:0] pal;
    int          addr;
    int          sel;
    logic [11:0] rgb;
  } pix_vec_t;

  localparam int NVEC = 14;
  pix_vec_t    vecs[NVEC];
  logic [11:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else
      $display("ok   %s: %0h", name, act);
  endtask

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic set_pal(input logic [11:0] p);
    rom_bus.pal_r = p[11:8];
    rom_bus.pal_g = p[7:4];
    rom_bus.pal_b = p[3:0];
  endtask

  task automatic park();
    DrawX = 10'd700;
    DrawY = 10'd500;
    blank = 1'b0;
  endtask

  task automatic pop_check(input string name);
    logic [11:0] e;
    if (exp_q.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL %s: scoreboard empty, got %0h expected a queued pixel", name, {red, green, blue});
    end else begin
      e = exp_q.pop_front();
      check(name, int'({red, green, blue}), int'(e));
    end
  endtask

  // One pixel through the pipeline, address on edge 1, palette for edge 2.
  task automatic drive_pixel(input string name, input int x, input int y, input bit b,
                             input logic [11:0] p, input logic [11:0] exp_rgb);
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = b;
    exp_q.push_back(exp_rgb);
    tick();
    park();
    set_pal(p);
    tick();
    pop_check(name);
  endtask

  task automatic pulse_tick();
    step_tick = 1'b1;
    tick();
    step_tick = 1'b0;
  endtask

  task automatic toggle(input int r, input int c);
    pad_toggle = 1'b1;
    pad_row    = 2'(r);
    pad_col    = 4'(c);
    tick();
    pad_toggle = 1'b0;
  endtask

  initial begin
    int exp_step;
    // cur_step=3, pattern bits (0,3) and (1,1) set when this table is applied
    vecs[0]  = '{45,  200, 1'b1, 12'hABC, 5,    1, 12'hABC};
    vecs[1]  = '{45,  200, 1'b0, 12'hABC, 5,    1, 12'h000};
    vecs[2]  = '{300, 100, 1'b1, 12'hABC, 0,    0, 12'h111};
    vecs[3]  = '{300, 320, 1'b1, 12'hABC, 0,    0, 12'h111};
    vecs[4]  = '{300, 159, 1'b1, 12'hABC, 0,    0, 12'h111};
    vecs[5]  = '{0,   160, 1'b1, 12'hABC, 0,    0, 12'h223};
    vecs[6]  = '{39,  160, 1'b1, 12'hABC, 0,    0, 12'h333};
    vecs[7]  = '{34,  194, 1'b1, 12'hABC, 1224, 0, 12'h223};
    vecs[8]  = '{35,  170, 1'b1, 12'hABC, 0,    0, 12'h333};
    vecs[9]  = '{156, 170, 1'b1, 12'hABC, 0,    0, 12'hFF0};
    vecs[10] = '{125, 165, 1'b1, 12'hABC, 180,  0, 12'hEFC};
    vecs[11] = '{130, 210, 1'b1, 12'hABC, 360,  1, 12'h667};
    vecs[12] = '{639, 319, 1'b1, 12'hABC, 0,    3, 12'h333};
    vecs[13] = '{45,  210, 1'b1, 12'h5F0, 355,  1, 12'h5F0};

    Reset = 1'b1; run = 1'b0; restart = 1'b0; step_tick = 1'b0; pad_toggle = 1'b0;
    pad_row = 2'd0; pad_col = 4'd0;
    park();
    set_pal(12'h000);
    tick();
    tick();
    check("reset_step", int'(step), 0);
    check("reset_trig", int'(trig), 0);
    check("reset_rgb", int'({red, green, blue}), 0);
    check("reset_addr", int'(rom_bus.rom_address), 0);
    check("reset_sel", int'(rom_bus.rom_sel), 0);
    Reset = 1'b0;
    tick();

    // 17 advances on an empty pattern
    run = 1'b1;
    exp_step = 0;
    for (int i = 0; i < 17; i++) begin
      pulse_tick();
      exp_step = (exp_step + 1) % 16;
      check($sformatf("run_step%0d", i), int'(step), exp_step);
      check($sformatf("run_trig%0d", i), int'(trig), 0);
    end
    for (int i = 0; i < 3; i++) begin
      pulse_tick();
      exp_step = (exp_step + 1) % 16;
    end
    check("at_step4", int'(step), 4);

    toggle(2, 5);
    pulse_tick();
    check("adv_step5", int'(step), 5);
    check("trig_row2", int'(trig), 4'b0100);
    tick();
    check("trig_one_cycle", int'(trig), 0);

    toggle(2, 5);
    for (int i = 0; i < 16; i++) begin
      pulse_tick();
      check($sformatf("cleared_trig%0d", i), int'(trig), 0);
    end
    check("back_step5", int'(step), 5);

    // toggle, tick and restart together
    pad_toggle = 1'b1; pad_row = 2'd0; pad_col = 4'd3;
    step_tick = 1'b1; restart = 1'b1;
    tick();
    pad_toggle = 1'b0; step_tick = 1'b0; restart = 1'b0;
    check("restart_step", int'(step), 0);
    check("restart_trig", int'(trig), 0);
    pulse_tick();
    pulse_tick();
    check("pre3_trig", int'(trig), 0);
    pulse_tick();
    check("step3", int'(step), 3);
    check("trig_row0_landed", int'(trig), 4'b0001);

    run = 1'b0;
    pulse_tick();
    check("norun_step", int'(step), 3);
    check("norun_trig", int'(trig), 0);

    // set (1,1), latch cursor at step 3, then the table
    toggle(1, 1);
    drive_pixel("latch_origin", 0, 0, 1'b1, 12'hABC, 12'h111);

    for (int i = 0; i <= NVEC; i++) begin
      if (i < NVEC) begin
        DrawX = 10'(vecs[i].x);
        DrawY = 10'(vecs[i].y);
        blank = vecs[i].b;
        exp_q.push_back(vecs[i].rgb);
      end else
        park();
      if (i >= 1) set_pal(vecs[i-1].pal);
      tick();
      if (i < NVEC) begin
        check($sformatf("vec%0d_addr", i), int'(rom_bus.rom_address), vecs[i].addr);
        check($sformatf("vec%0d_sel", i), int'(rom_bus.rom_sel), vecs[i].sel);
      end
      if (i >= 1) pop_check($sformatf("vec%0d_rgb", i - 1));
    end

    // step moves mid-frame; cursor waits for the origin pixel
    run = 1'b1;
    pulse_tick();
    run = 1'b0;
    check("midframe_step4", int'(step), 4);
    drive_pixel("old_cursor_col3", 156, 170, 1'b1, 12'hABC, 12'hFF0);
    drive_pixel("not_yet_col4", 196, 170, 1'b1, 12'hABC, 12'h333);
    drive_pixel("frame_latch", 0, 0, 1'b1, 12'hABC, 12'h111);
    drive_pixel("new_cursor_col4", 196, 170, 1'b1, 12'hABC, 12'hFF0);
    drive_pixel("old_col3_gutter", 156, 170, 1'b1, 12'hABC, 12'h333);

    // reset mid-line with a pixel held on the inputs
    DrawX = 10'd45; DrawY = 10'd200; blank = 1'b1;
    set_pal(12'hABC);
    tick();
    tick();
    check("preline_rgb", int'({red, green, blue}), 12'hABC);
    Reset = 1'b1;
    tick();
    check("midreset_rgb", int'({red, green, blue}), 0);
    check("midreset_step", int'(step), 0);
    check("midreset_addr", int'(rom_bus.rom_address), 0);
    Reset = 1'b0;
    tick();
    check("refill1_rgb", int'({red, green, blue}), 0);
    check("refill1_addr", int'(rom_bus.rom_address), 5);
    tick();
    check("refill2_rgb_dim", int'({red, green, blue}), 12'h223);
    park();
    tick();
    drive_pixel("reset_cursor_col0", 36, 170, 1'b1, 12'hABC, 12'hFF0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
